// File: rtl/riscv_pkg.sv
// Shared types for the execute-stage hazard unit: forwarding selects, scoreboard stage
// record and the register-hit / forward-priority helpers.
package riscv_pkg;

    localparam int HZ_AW = 5;
    localparam logic [HZ_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [HZ_AW-1:0] rs1;
        logic [HZ_AW-1:0] rs2;
        logic [HZ_AW-1:0] rd;
        logic             regwrite;
        logic             load;
    } hz_stage_t;

    localparam hz_stage_t HZ_BUBBLE = '0;

    // x0 is hard-wired zero, so a write to it never produces a dependency.
    function automatic logic stage_hit(input hz_stage_t s, input logic [HZ_AW-1:0] r);
        return s.regwrite && (s.rd != REG_ZERO) && (s.rd == r);
    endfunction

    function automatic fwd_sel_t fwd_select(input hz_stage_t m, input hz_stage_t w,
                                            input logic [HZ_AW-1:0] r);
        if (stage_hit(m, r)) begin
            return FWD_MEM;
        end else if (stage_hit(w, r)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One scoreboard pipeline stage: async reset plus synchronous clear that inserts a bubble.
import riscv_pkg::*;

module hz_stage_reg (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clr_i,
    input  hz_stage_t d_i,
    output hz_stage_t q_o
);

    hz_stage_t stage_q;

    // Stage register; clear takes priority over load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= HZ_BUBBLE;
        end else if (clr_i) begin
            stage_q <= HZ_BUBBLE;
        end else begin
            stage_q <= d_i;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and stall/flush generator with its own E/M/W destination scoreboard.
// HAZARD_FORWARDING_EN selects the forwarding core; without it the unit interlocks only.
import riscv_pkg::*;

module fwd_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_AW-1:0]    rs1_d,
    input  logic [REG_AW-1:0]    rs2_d,
    input  logic [REG_AW-1:0]    rd_d,
    input  logic                 regwrite_d,
    input  logic                 load_d,
    input  logic                 pcsrc_e,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    hz_stage_t d_stage_s;
    hz_stage_t e_q;
    hz_stage_t m_q;
    hz_stage_t w_q;
    logic      stall_s;
    logic      unused_s;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    assign d_stage_s = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, regwrite: regwrite_d, load: load_d};

    hz_stage_reg u_stage_e (.clk_i(clk), .rst_i(reset), .clr_i(flush_e), .d_i(d_stage_s), .q_o(e_q));
    hz_stage_reg u_stage_m (.clk_i(clk), .rst_i(reset), .clr_i(1'b0),    .d_i(e_q),       .q_o(m_q));
    hz_stage_reg u_stage_w (.clk_i(clk), .rst_i(reset), .clr_i(1'b0),    .d_i(m_q),       .q_o(w_q));

`ifdef HAZARD_FORWARDING_EN
    // Only a load in E cannot be forwarded in time; everything else is bypassed.
    always_comb begin
        stall_s = e_q.load & (stage_hit(e_q, rs1_d) | stage_hit(e_q, rs2_d));
    end

    // Select mux inputs from scoreboard state only; reset parks both on the register file.
    always_comb begin
        if (reset) begin
            fwd_a_e = FWD_RF;
            fwd_b_e = FWD_RF;
        end else begin
            fwd_a_e = fwd_select(m_q, w_q, e_q.rs1);
            fwd_b_e = fwd_select(m_q, w_q, e_q.rs2);
        end
    end

    assign unused_s = ^{w_q.rs1, w_q.rs2, w_q.load};
`else
    // No bypass paths: hold decode until the producer has reached W.
    always_comb begin
        stall_s = stage_hit(e_q, rs1_d) | stage_hit(e_q, rs2_d)
                | stage_hit(m_q, rs1_d) | stage_hit(m_q, rs2_d);
    end

    assign fwd_a_e  = FWD_RF;
    assign fwd_b_e  = FWD_RF;
    assign unused_s = ^w_q;
`endif

    assign stall_f = stall_s & ~reset;
    assign stall_d = stall_s & ~reset;
    assign flush_d = pcsrc_e & ~reset;
    assign flush_e = (stall_s | pcsrc_e) & ~reset;

    // Saturating stall-cycle count.
    always_comb begin
        if (stall_d && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Table-driven bench for fwd_hazard_unit; expectations follow whichever build
// (HAZARD_FORWARDING_EN defined or not) is compiled.
module tb_fwd_hazard_unit;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rw, ld, pc;
        logic [7:0]  outs;   // {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e}
        logic [31:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_d = 5'd0, rs2_d = 5'd0, rd_d = 5'd0;
    logic        regwrite_d = 1'b0, load_d = 1'b0, pcsrc_e = 1'b0;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [31:0] stall_cnt;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    fwd_hazard_unit #(.REG_AW(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int rs1, input int rs2, input int rd, input bit rw,
                                input bit ld, input bit pc, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [3:0] ctl, input int cnt);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.rw = rw; v.ld = ld; v.pc = pc;
        v.outs = {fa, fb, ctl};
        v.cnt = 32'(cnt);
        return v;
    endfunction

    function automatic logic [7:0] outs_now();
        return {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_d = v.rs1; rs2_d = v.rs2; rd_d = v.rd;
        regwrite_d = v.rw; load_d = v.ld; pcsrc_e = v.pc;
    endtask

    initial begin
        vec_t got;
`ifdef HAZARD_FORWARDING_EN
        //            rs1 rs2 rd rw ld pc  fa     fb     sf/sd/fd/fe cnt
        tbl.push_back(mk(1, 0, 5, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0)); // addi x5
        tbl.push_back(mk(5, 6, 8, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0)); // add uses x5
        tbl.push_back(mk(5, 0, 9, 1, 0, 0, 2'b10, 2'b00, 4'b0000, 0)); // MEM forward
        tbl.push_back(mk(2, 0, 7, 1, 1, 0, 2'b01, 2'b00, 4'b0000, 0)); // WB forward; lw x7
        tbl.push_back(mk(3, 7,10, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 0)); // load-use stall
        tbl.push_back(mk(3, 7,10, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1)); // bubble in E
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0000, 1)); // load data via WB
        tbl.push_back(mk(0, 0, 3, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1)); // write x3
        tbl.push_back(mk(0, 0, 3, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1)); // write x3 again
        tbl.push_back(mk(3, 0,11, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1)); // consumer of x3
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 4'b0000, 1)); // M beats W; write x0
        tbl.push_back(mk(0, 0,12, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 1)); // x0 in M: no fwd; lw x0
        tbl.push_back(mk(0, 0,13, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 1)); // lw x0: no stall
        tbl.push_back(mk(1, 0, 6, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 1)); // lw x6
        tbl.push_back(mk(6, 0,14, 1, 0, 1, 2'b00, 2'b00, 4'b1111, 1)); // lwstall + branch
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2)); // bubble in E
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2));
`else
        tbl.push_back(mk(1, 0, 4, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0)); // addi x4
        tbl.push_back(mk(4, 0, 8, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 0)); // E hit
        tbl.push_back(mk(4, 0, 8, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 1)); // M hit
        tbl.push_back(mk(4, 0, 8, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2)); // W: no stall
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2)); // write x0
        tbl.push_back(mk(0, 0, 9, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2)); // x0 never hits
        tbl.push_back(mk(3, 9,10, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 2)); // rs2 hit in E
        tbl.push_back(mk(3, 9,10, 1, 0, 1, 2'b00, 2'b00, 4'b1111, 3)); // M hit + branch
        tbl.push_back(mk(9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 4)); // W hit only
        tbl.push_back(mk(1, 2, 5, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 4)); // no regwrite
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 4)); // rd5 rw0: no hit
        tbl.push_back(mk(0, 0, 7, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 4)); // lw x7
        tbl.push_back(mk(0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 4));
        tbl.push_back(mk(0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 4'b1101, 5));
        tbl.push_back(mk(0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 6));
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", 32'(outs_now()), 32'h0);
        check("reset cnt", stall_cnt, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            check($sformatf("row%0d outs", i), 32'(outs_now()), 32'(got.outs));
            check($sformatf("row%0d cnt", i), stall_cnt, got.cnt);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a dependent instruction is stalled behind lw x5
        drive(mk(0, 0, 5, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 0));
        @(posedge clk);
        #1;
        drive(mk(5, 0, 6, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
        @(negedge clk);
        check("pre-reset stall_d", 32'(stall_d), 32'h1);
        #1;
        reset = 1'b1;
        pcsrc_e = 1'b1;
        #1;
        check("in-reset outs", 32'(outs_now()), 32'h0);
        check("in-reset cnt", stall_cnt, 32'h0);
        @(posedge clk);
        #1;
        pcsrc_e = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post-reset outs", 32'(outs_now()), 32'h0);
        @(posedge clk);
        #1;
        check("post-reset cnt", stall_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
